// File: rtl/udp_frame_pkg.sv
// Shared types and elaboration-time header generation for the UDP frame builder.
// The header is a constant nibble vector: nibble 2*i is the low nibble of header byte i.
package udp_frame_pkg;

    localparam int HDR_NIBBLES = 84;
    localparam int HDR_BITS    = 4 * HDR_NIBBLES;
    localparam int MAX_PAYLOAD = 1472;
    localparam int PCNT_W      = $clog2(2 * MAX_PAYLOAD);
    localparam int HIDX_W      = $clog2(HDR_NIBBLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_DROP
    } state_t;

    // Ones-complement sum over the IPv4 header words; id and checksum words are zero.
    function automatic logic [15:0] ip_csum(
        input logic [31:0] src,
        input logic [31:0] dst,
        input logic [15:0] len
    );
        logic [19:0] sum;
        sum = 20'h04500 + 20'(len) + 20'h04000 + 20'h04011
            + 20'(src[31:16]) + 20'(src[15:0])
            + 20'(dst[31:16]) + 20'(dst[15:0]);
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        sum = 20'(sum[15:0]) + 20'(sum[19:16]);
        return ~sum[15:0];
    endfunction

    function automatic logic [HDR_BITS-1:0] build_hdr(
        input logic [47:0] dst_mac,
        input logic [47:0] src_mac,
        input logic [31:0] src_ip,
        input logic [31:0] dst_ip,
        input logic [15:0] src_port,
        input logic [15:0] dst_port,
        input logic [15:0] payload_bytes
    );
        logic [HDR_BITS-1:0] bytes_be;
        logic [HDR_BITS-1:0] nib;
        logic [15:0]         ip_len;
        logic [15:0]         udp_len;
        ip_len  = 16'd28 + payload_bytes;
        udp_len = 16'd8 + payload_bytes;
        bytes_be = {dst_mac, src_mac, 16'h0800,
                    16'h4500, ip_len, 16'h0000, 16'h4000, 16'h4011,
                    ip_csum(src_ip, dst_ip, ip_len), src_ip, dst_ip,
                    src_port, dst_port, udp_len, 16'h0000};
        // Byte-reverse so byte 0 (first on the wire) lands in the low bits.
        for (int i = 0; i < HDR_BITS / 8; i++) begin
            nib[8*i +: 8] = bytes_be[HDR_BITS-1-8*i -: 8];
        end
        return nib;
    endfunction

endpackage

// File: rtl/udp_hdr_rom.sv
// Constant 84 x 4 header lookup, combinational, indexed by header nibble position.
module udp_hdr_rom
    import udp_frame_pkg::*;
#(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP        = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP        = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT      = 16'd4000,
    parameter logic [15:0] DST_PORT      = 16'd4001,
    parameter int          PAYLOAD_BYTES = 1024
) (
    input  logic [HIDX_W-1:0] hidx,
    output logic [3:0]        dat
);

    localparam logic [HDR_BITS-1:0] HDR = build_hdr(DST_MAC, SRC_MAC, SRC_IP, DST_IP,
                                                    SRC_PORT, DST_PORT, 16'(PAYLOAD_BYTES));

    always_comb begin
        dat = 4'h0;
        if (hidx < HIDX_W'(HDR_NIBBLES)) begin
            dat = HDR[{hidx, 2'b00} +: 4];
        end
    end

endmodule

// File: rtl/udp_frame_builder.sv
// Prepends a constant Ethernet/IPv4/UDP header to the upstream nibble stream and
// forces every frame to exactly PAYLOAD_BYTES of payload (zero pad / truncate).
module udp_frame_builder
    import udp_frame_pkg::*;
#(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP        = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP        = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT      = 16'd4000,
    parameter logic [15:0] DST_PORT      = 16'd4001,
    parameter int          PAYLOAD_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iVld,
    input  logic       iEof,
    input  logic [3:0] iDat,
    output logic       iReady,
    output logic       oVld,
    output logic       oEof,
    output logic [3:0] oDat,
    input  logic       iAck,
    output logic       errShort,
    output logic       errLong
);

    localparam logic [PCNT_W-1:0] PLAST = PCNT_W'(2 * PAYLOAD_BYTES - 1);
    localparam logic [HIDX_W-1:0] HLAST = HIDX_W'(HDR_NIBBLES - 1);

    state_t              state, state_nx;
    logic [HIDX_W-1:0]   hidx, hidx_nx;
    logic [PCNT_W-1:0]   pcnt, pcnt_nx;
    logic                err_short_nx, err_long_nx;
    logic [3:0]          hdr_dat;
    logic                last;

    udp_hdr_rom #(
        .DST_MAC      (DST_MAC),
        .SRC_MAC      (SRC_MAC),
        .SRC_IP       (SRC_IP),
        .DST_IP       (DST_IP),
        .SRC_PORT     (SRC_PORT),
        .DST_PORT     (DST_PORT),
        .PAYLOAD_BYTES(PAYLOAD_BYTES)
    ) u_hdr_rom (
        .hidx(hidx),
        .dat (hdr_dat)
    );

    assign last = (pcnt == PLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hidx     <= '0;
            pcnt     <= '0;
            errShort <= 1'b0;
            errLong  <= 1'b0;
        end else begin
            state    <= state_nx;
            hidx     <= hidx_nx;
            pcnt     <= pcnt_nx;
            errShort <= err_short_nx;
            errLong  <= err_long_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hidx_nx      = hidx;
        pcnt_nx      = pcnt;
        err_short_nx = 1'b0;
        err_long_nx  = 1'b0;
        oVld         = 1'b0;
        oEof         = 1'b0;
        oDat         = 4'h0;
        iReady       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iVld) begin
                    state_nx = ST_HDR;
                    hidx_nx  = '0;
                end
            end
            ST_HDR: begin
                oVld = 1'b1;
                oDat = hdr_dat;
                if (iAck) begin
                    if (hidx == HLAST) begin
                        state_nx = ST_PAY;
                        pcnt_nx  = '0;
                    end else begin
                        hidx_nx = hidx + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                // Zero-latency pass-through: upstream handshake follows tx_mac's ack.
                oVld   = iVld;
                oDat   = iDat;
                oEof   = last;
                iReady = iAck;
                if (iVld && iAck) begin
                    pcnt_nx = pcnt + 1'b1;
                    if (iEof && last) begin
                        state_nx = ST_IDLE;
                    end else if (iEof) begin
                        state_nx     = ST_PAD;
                        err_short_nx = 1'b1;
                    end else if (last) begin
                        state_nx    = ST_DROP;
                        err_long_nx = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                oVld = 1'b1;
                oEof = last;
                if (iAck) begin
                    if (last) begin
                        state_nx = ST_IDLE;
                    end else begin
                        pcnt_nx = pcnt + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                // Swallow the rest of an over-long upstream frame.
                iReady = 1'b1;
                if (iVld && iEof) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_udp_frame_builder.sv
// Scoreboard bench: expected nibble streams come from a byte-level frame model; a monitor pops on each output transfer.
module tb_udp_frame_builder;

    localparam int PB     = 18;
    localparam int PN     = 2 * PB;
    localparam int HN     = 84;
    localparam int PB_DEF = 1024;

    typedef struct packed {
        logic [3:0] dat;
        logic       eof;
    } nib_t;
    typedef logic [3:0] dq_t[$];
    typedef nib_t       nq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_ivld, a_ieof, a_iready, a_ovld, a_oeof, a_iack, a_es, a_el;
    logic [3:0] a_idat, a_odat;
    logic       b_ivld, b_ieof, b_iready, b_ovld, b_oeof, b_iack, b_es, b_el;
    logic [3:0] b_idat, b_odat;

    udp_frame_builder #(.PAYLOAD_BYTES(PB)) dut_a (
        .clk(clk), .rst(rst), .iVld(a_ivld), .iEof(a_ieof), .iDat(a_idat), .iReady(a_iready),
        .oVld(a_ovld), .oEof(a_oeof), .oDat(a_odat), .iAck(a_iack),
        .errShort(a_es), .errLong(a_el)
    );

    udp_frame_builder dut_b (
        .clk(clk), .rst(rst), .iVld(b_ivld), .iEof(b_ieof), .iDat(b_idat), .iReady(b_iready),
        .oVld(b_ovld), .oEof(b_oeof), .oDat(b_odat), .iAck(b_iack),
        .errShort(b_es), .errLong(b_el)
    );

    int   vecs = 0;
    int   errs = 0;
    nq_t  exp_a, exp_b, cap_a, cap_b;
    int   es_cnt = 0, el_cnt = 0, es_exp = 0, el_exp = 0;
    bit   chk_en = 1'b1;
    bit   ack_rand = 1'b0;
    int   gap_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame: header bytes in wire order, then payload padded/truncated to 2*pb nibbles.
    function automatic nq_t expect_frame(input int pb, input dq_t data);
        int unsigned h[42];
        int unsigned s;
        int tl, ul;
        nq_t q;
        tl = 28 + pb;
        ul = 8 + pb;
        h = '{255, 255, 255, 255, 255, 255,
              2, 0, 0, 0, 0, 1,
              8, 0,
              69, 0, tl >> 8, tl & 255, 0, 0, 64, 0, 64, 17, 0, 0,
              192, 168, 1, 10, 192, 168, 1, 1,
              4000 >> 8, 4000 & 255, 4001 >> 8, 4001 & 255, ul >> 8, ul & 255, 0, 0};
        s = 0;
        for (int k = 14; k < 34; k += 2) s += h[k] * 256 + h[k+1];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s & 32'hFFFF;
        h[24] = s >> 8;
        h[25] = s & 255;
        for (int k = 0; k < 42; k++) begin
            q.push_back('{dat: 4'(h[k] & 15), eof: 1'b0});
            q.push_back('{dat: 4'(h[k] >> 4), eof: 1'b0});
        end
        for (int i = 0; i < 2 * pb; i++) begin
            q.push_back('{dat: (i < data.size()) ? data[i] : 4'h0, eof: (i == 2 * pb - 1)});
        end
        return q;
    endfunction

    initial begin
        a_iack = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_iack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for DUT A: scoreboard pop, stall stability, error pulse counting.
    logic [3:0] pd;
    logic       pe;
    bit         pstall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pstall = 1'b0;
        end else begin
            if (chk_en && pstall) begin
                check("stall_vld", a_ovld, 1);
                check("stall_dat", a_odat, pd);
                check("stall_eof", a_oeof, pe);
            end
            if (chk_en && a_ovld && a_iack) begin
                if (exp_a.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_out_a: got %0h expected none at %0t", a_odat, $time);
                end else begin
                    nib_t e;
                    e = exp_a.pop_front();
                    check("out_dat_a", a_odat, e.dat);
                    check("out_eof_a", a_oeof, e.eof);
                end
                cap_a.push_back('{dat: a_odat, eof: a_oeof});
            end
            if (a_es) es_cnt++;
            if (a_el) el_cnt++;
            pstall = a_ovld && !a_iack;
            pd = a_odat;
            pe = a_oeof;
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ovld && b_iack) begin
            if (exp_b.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_out_b: got %0h expected none at %0t", b_odat, $time);
            end else begin
                nib_t e;
                e = exp_b.pop_front();
                check("out_dat_b", b_odat, e.dat);
                check("out_eof_b", b_oeof, e.eof);
            end
            cap_b.push_back('{dat: b_odat, eof: b_oeof});
        end
        if (!rst && (b_es || b_el)) check("err_b", 1, 0);
    end

    task automatic drive_a(input logic [3:0] d, input logic e);
        int waited = 0;
        a_ivld = 1'b1;
        a_idat = d;
        a_ieof = e;
        forever begin
            @(negedge clk);
            if (a_iready) break;
            waited++;
            if (waited > 3000) begin
                check("upstream_timeout_a", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_ivld = 1'b0;
        a_ieof = 1'b0;
        a_idat = 4'($urandom);
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_b(input logic [3:0] d, input logic e);
        int waited = 0;
        b_ivld = 1'b1;
        b_idat = d;
        b_ieof = e;
        forever begin
            @(negedge clk);
            if (b_iready) break;
            waited++;
            if (waited > 3000) begin
                check("upstream_timeout_b", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        b_ivld = 1'b0;
        b_ieof = 1'b0;
    endtask

    task automatic frame_a(input int n);
        dq_t d;
        nq_t e;
        int  t;
        for (int i = 0; i < n; i++) d.push_back(4'($urandom));
        e = expect_frame(PB, d);
        foreach (e[i]) exp_a.push_back(e[i]);
        if (n < PN) es_exp++;
        if (n > PN) el_exp++;
        cap_a.delete();
        for (int i = 0; i < n; i++) drive_a(d[i], i == n - 1);
        t = 0;
        while (exp_a.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("drain_a", exp_a.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("errShort_count", es_cnt, es_exp);
        check("errLong_count", el_cnt, el_exp);
        check("frame_len_a", cap_a.size(), HN + PN);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t, eofs;
        dq_t  d;
        nq_t  e;
        logic [3:0] ref29[6];
        rst = 1'b1;
        a_ivld = 1'b0; a_ieof = 1'b0; a_idat = 4'h0;
        b_ivld = 1'b0; b_ieof = 1'b0; b_idat = 4'h0; b_iack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oVld", a_ovld, 0);
        check("rst_iReady", a_iready, 0);
        check("rst_oEof", a_oeof, 0);
        check("rst_oDat", a_odat, 0);
        check("rst_errShort", a_es, 0);
        check("rst_errLong", a_el, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal frame, full rate
        frame_a(PN);
        if (cap_a.size() == HN + PN) begin
            ref29 = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h5, 4'h4};
            for (int i = 0; i < 12; i++) check("dst_mac_nib", cap_a[i].dat, 4'hF);
            for (int i = 0; i < 6; i++) check("etype_ver_nib", cap_a[24+i].dat, ref29[i]);
            eofs = 0;
            foreach (cap_a[i]) eofs += int'(cap_a[i].eof);
            check("eof_count", eofs, 1);
            check("eof_last", cap_a[HN+PN-1].eof, 1);
        end

        // Backpressure and gapped upstream
        ack_rand = 1'b1;
        gap_max = 2;
        repeat (3) frame_a(PN);

        // Short, long, and a clean frame afterwards
        frame_a(10);
        frame_a(50);
        frame_a(PN);
        ack_rand = 1'b0;
        gap_max = 0;
        frame_a(10);
        frame_a(50);
        ack_rand = 1'b1;
        gap_max = 1;
        repeat (4) frame_a($urandom_range(1, 60));

        // Reset in the middle of the payload (pcnt=5)
        ack_rand = 1'b0;
        gap_max = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        for (int i = 0; i < 5; i++) drive_a(4'($urandom), 1'b0);
        a_ivld = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_ivld = 1'b0;
        @(negedge clk);
        check("post_rst_oVld", a_ovld, 0);
        check("post_rst_iReady", a_iready, 0);
        exp_a.delete();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        frame_a(PN);

        // Default parameters: 1024-byte payload
        for (int i = 0; i < 2 * PB_DEF; i++) d.push_back(4'($urandom));
        e = expect_frame(PB_DEF, d);
        foreach (e[i]) exp_b.push_back(e[i]);
        for (int i = 0; i < 2 * PB_DEF; i++) drive_b(d[i], i == 2 * PB_DEF - 1);
        t = 0;
        while (exp_b.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("drain_b", exp_b.size(), 0);
        check("frame_len_b", cap_b.size(), 2132);
        if (cap_b.size() == 2132) begin
            check("ip_len_n32", cap_b[32].dat, 4'h4);
            check("ip_len_n33", cap_b[33].dat, 4'h0);
            check("ip_len_n34", cap_b[34].dat, 4'hC);
            check("ip_len_n35", cap_b[35].dat, 4'h1);
            check("udp_len_n76", cap_b[76].dat, 4'h4);
            check("udp_len_n77", cap_b[77].dat, 4'h0);
            check("udp_len_n78", cap_b[78].dat, 4'h8);
            check("udp_len_n79", cap_b[79].dat, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
